// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-ROM fetch arbiter: requester owner tag and
// the in-flight tag record carried down the ROM latency pipe.
package imem_arb_pkg;

  localparam int unsigned LATENCY_MAX = 4;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;
    owner_e owner;
  } tag_t;

  // A fetch redirect kills fetch-owned tags only; debug tags pass untouched.
  function automatic tag_t killFetch(input tag_t t, input logic flushF);
    tag_t r;
    r = t;
    if (flushF && (t.owner == OWN_F)) r.vld = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// Bus bundle between the two ROM requesters (fetch, debug), the arbiter and the ROM.
interface imem_fetch_arbiter_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic              f_req_vld;
    logic [31:0]       f_req_addr;
    logic              f_req_rdy;
    logic              f_flush;
    logic              f_rsp_vld;
    logic [DATA_W-1:0] f_rsp_data;
    logic              d_req_vld;
    logic [31:0]       d_req_addr;
    logic              d_req_rdy;
    logic              d_rsp_vld;
    logic [DATA_W-1:0] d_rsp_data;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  f_req_vld, f_req_addr, f_flush, d_req_vld, d_req_addr, mem_rd,
        output f_req_rdy, f_rsp_vld, f_rsp_data, d_req_rdy, d_rsp_vld, d_rsp_data, mem_a
    );

    modport master (
        output f_req_vld, f_req_addr, f_flush, d_req_vld, d_req_addr, mem_rd,
        input  f_req_rdy, f_rsp_vld, f_rsp_data, d_req_rdy, d_rsp_vld, d_rsp_data, mem_a
    );
endinterface

// File: rtl/imem_arb_tag_pipe.sv
// Owner/valid tag shift register matching the ROM read latency, with a
// fetch-selective kill applied to every tag already in flight.
module imem_arb_tag_pipe #(
    parameter int unsigned LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  imem_arb_pkg::owner_e loadOwner,
    input  logic                flushF,
    output imem_arb_pkg::tag_t   tail
);
    import imem_arb_pkg::*;

    if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : gBadLatency
        $fatal(1, "imem_arb_tag_pipe: LATENCY=%0d outside 1..%0d", LATENCY, LATENCY_MAX);
    end

    tag_t stage [LATENCY];

    // Stage 0 takes the new tag unkilled: a fetch accepted in the flush cycle is on the new path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else begin
            stage[0] <= '{vld: load, owner: loadOwner};
            for (int unsigned i = 1; i < LATENCY; i++) stage[i] <= killFetch(stage[i-1], flushF);
        end
    end

    assign tail = stage[LATENCY-1];

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Round-robin arbiter sharing one fixed-latency instruction ROM between CPU fetch
// and a debug/loader reader; read data is steered back to its owner by tag.
module imem_fetch_arbiter #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 1
) (
    input logic                 clk,
    input logic                 rst,
    imem_fetch_arbiter_if.slave bus
);
    import imem_arb_pkg::*;

    owner_e            lastGrant;
    owner_e            winner;
    logic              fGrant;
    logic              dGrant;
    logic              xfer;
    logic [ADDR_W-1:0] memA;
    logic [ADDR_W-1:0] memAHold;
    tag_t              tail;

    // Grant is combinational; rst gates it so no handshake completes while held in reset.
    always_comb begin
        fGrant = 1'b0;
        dGrant = 1'b0;
        if (!rst) begin
            if (bus.f_req_vld && bus.d_req_vld) begin
                fGrant = (lastGrant == OWN_D);
                dGrant = (lastGrant == OWN_F);
            end else begin
                fGrant = bus.f_req_vld;
                dGrant = bus.d_req_vld;
            end
        end
    end

    assign xfer   = fGrant | dGrant;
    assign winner = dGrant ? OWN_D : OWN_F;

    always_comb begin
        memA = memAHold;
        if (fGrant)      memA = bus.f_req_addr[ADDR_W-1:0];
        else if (dGrant) memA = bus.d_req_addr[ADDR_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrant <= OWN_D;
            memAHold  <= '0;
        end else if (xfer) begin
            lastGrant <= winner;
            memAHold  <= memA;
        end
    end

    imem_arb_tag_pipe #(
        .LATENCY(LATENCY)
    ) tagPipe (
        .clk      (clk),
        .rst      (rst),
        .load     (xfer),
        .loadOwner(winner),
        .flushF   (bus.f_flush),
        .tail     (tail)
    );

    assign bus.f_req_rdy  = fGrant;
    assign bus.d_req_rdy  = dGrant;
    assign bus.mem_a      = memA;
    assign bus.f_rsp_vld  = tail.vld && (tail.owner == OWN_F) && !bus.f_flush;
    assign bus.d_rsp_vld  = tail.vld && (tail.owner == OWN_D);
    assign bus.f_rsp_data = bus.mem_rd;
    assign bus.d_rsp_data = bus.mem_rd;

    if (ADDR_W < 32) begin : gAddrWrap
        logic unusedAddrBits;
        assign unusedAddrBits = ^{bus.f_req_addr[31:ADDR_W], bus.d_req_addr[31:ADDR_W]};
    end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Drives one shared request stream into arbiters built for LATENCY 1..4, each
// with its own ROM model and a queue-based scoreboard of expected responses.
module tb_imem_fetch_arbiter;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NLAT   = 4;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fVld = 1'b0, dVld = 1'b0, fFlush = 1'b0;
    logic [31:0] fAddr = '0, dAddr = '0;
    logic        fRdyA [NLAT];
    logic        dRdyA [NLAT];
    logic        fGot, dGot;
    int          cyc = 0;
    int          nChecks = 0;
    int          nFails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] romWord(input logic [31:0] a);
        return 32'hA000_0000 + (a & ((32'd1 << ADDR_W) - 32'd1));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < NLAT; g++) begin : gLat
        localparam int unsigned LAT = g + 1;

        imem_fetch_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
        logic [DATA_W-1:0] romPipe [LAT];

        imem_fetch_arbiter #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .LATENCY(LAT)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );

        assign bus.f_req_vld  = fVld;
        assign bus.f_req_addr = fAddr;
        assign bus.f_flush    = fFlush;
        assign bus.d_req_vld  = dVld;
        assign bus.d_req_addr = dAddr;
        assign bus.mem_rd     = romPipe[LAT-1];
        assign fRdyA[g]       = bus.f_req_rdy;
        assign dRdyA[g]       = bus.d_req_rdy;

        // ROM: word k = A0000000 + k, LAT clocks after the address
        always @(posedge clk) begin
            romPipe[0] <= romWord({{(32-ADDR_W){1'b0}}, bus.mem_a});
            for (int i = 1; i < int'(LAT); i++) romPipe[i] <= romPipe[i-1];
        end

        exp_t fq[$];
        exp_t dq[$];
        bit   lastWasD = 1'b1;

        always @(negedge clk) begin
            logic fG, dG, expF, expD;
            exp_t e;
            if (rst) begin
                check($sformatf("L%0d rst f_req_rdy", LAT), 64'(bus.f_req_rdy), 64'd0);
                check($sformatf("L%0d rst d_req_rdy", LAT), 64'(bus.d_req_rdy), 64'd0);
                check($sformatf("L%0d rst f_rsp_vld", LAT), 64'(bus.f_rsp_vld), 64'd0);
                check($sformatf("L%0d rst d_rsp_vld", LAT), 64'(bus.d_rsp_vld), 64'd0);
                check($sformatf("L%0d rst mem_a", LAT), 64'(bus.mem_a), 64'd0);
                fq.delete();
                dq.delete();
                lastWasD = 1'b1;
            end else begin
                fG = fVld && (!dVld || lastWasD);
                dG = dVld && (!fVld || !lastWasD);
                check($sformatf("L%0d f_req_rdy", LAT), 64'(bus.f_req_rdy), 64'(fG));
                check($sformatf("L%0d d_req_rdy", LAT), 64'(bus.d_req_rdy), 64'(dG));
                if (fG) check($sformatf("L%0d mem_a(F)", LAT), 64'(bus.mem_a), 64'(fAddr[ADDR_W-1:0]));
                else if (dG) check($sformatf("L%0d mem_a(D)", LAT), 64'(bus.mem_a), 64'(dAddr[ADDR_W-1:0]));

                if (fFlush) fq.delete();

                expF = (fq.size() > 0) && (fq[0].due == cyc);
                check($sformatf("L%0d f_rsp_vld", LAT), 64'(bus.f_rsp_vld), 64'(expF));
                if (expF) begin
                    e = fq.pop_front();
                    if (bus.f_rsp_vld) check($sformatf("L%0d f_rsp_data", LAT), 64'(bus.f_rsp_data), 64'(e.data));
                end

                expD = (dq.size() > 0) && (dq[0].due == cyc);
                check($sformatf("L%0d d_rsp_vld", LAT), 64'(bus.d_rsp_vld), 64'(expD));
                if (expD) begin
                    e = dq.pop_front();
                    if (bus.d_rsp_vld) check($sformatf("L%0d d_rsp_data", LAT), 64'(bus.d_rsp_data), 64'(e.data));
                end

                if (fG) fq.push_back('{due: cyc + int'(LAT), data: romWord(fAddr)});
                if (dG) dq.push_back('{due: cyc + int'(LAT), data: romWord(dAddr)});
                if (fG) lastWasD = 1'b0;
                else if (dG) lastWasD = 1'b1;
            end
        end
    end

    task automatic drive(input logic fv, input logic [31:0] fa, input logic dv,
                         input logic [31:0] da, input logic fl);
        fVld   = fv;
        fAddr  = fa;
        dVld   = dv;
        dAddr  = da;
        fFlush = fl;
        @(negedge clk);
        fGot = fRdyA[0];
        dGot = dRdyA[0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic        fv, dv, fl;
        logic [31:0] fa, da;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        for (int k = 0; k < 8; k++) drive(1'b1, 32'(k), 1'b0, '0, 1'b0);
        idle(6);

        repeat (8) drive(1'b1, 32'd4, 1'b1, 32'd9, 1'b0);
        idle(6);

        for (int k = 1; k <= 3; k++) drive(1'b1, 32'(k), 1'b0, '0, 1'b0);
        drive(1'b1, 32'd20, 1'b0, '0, 1'b1);
        idle(6);

        drive(1'b0, '0, 1'b1, 32'd5, 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        idle(6);

        drive(1'b1, 32'd7, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, 32'd8, 1'b0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        drive(1'b1, 32'd11, 1'b1, 32'd12, 1'b0);
        drive(1'b1, 32'd11, 1'b1, 32'd12, 1'b0);
        idle(6);

        drive(1'b1, 32'h0000_0403, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, 32'hFFFF_F805, 1'b0);
        idle(6);

        // Random traffic; a requester keeps vld/addr stable until it is accepted.
        fv = 1'b0; dv = 1'b0; fa = '0; da = '0;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                rst = 1'b1;
                fv = 1'b0;
                dv = 1'b0;
                idle(2);
                rst = 1'b0;
            end
            if (!fv) begin
                fv = ($urandom_range(0, 2) != 0);
                fa = $urandom;
            end
            if (!dv) begin
                dv = ($urandom_range(0, 2) != 0);
                da = $urandom;
            end
            fl = ($urandom_range(0, 7) == 0);
            drive(fv, fa, dv, da, fl);
            if (fGot) fv = 1'b0;
            if (dGot) dv = 1'b0;
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
